// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and IDLE -> ACCESS -> DONE sequencer for the 16 x 8 data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; the default build is round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_acc,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              win_q, win_d;      // 0 = port 0 owns the access, 1 = port 1
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              p0_gnt_q, p0_gnt_d;
    logic              p1_gnt_q, p1_gnt_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              any_req;
    logic              pick_p1;

    assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick_p1 = p1_req & ~p0_req;
`else
    // last_q = 1 means port 1 was granted last, so port 0 wins the next tie.
    logic last_q, last_d;

    assign pick_p1 = p1_req & (~p0_req | ~last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = pick_p1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        p0_gnt_d   = 1'b0;
        p1_gnt_d   = 1'b0;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d    = pick_p1;
                    we_d     = pick_p1 ? p1_we    : p0_we;
                    addr_d   = pick_p1 ? p1_addr  : p0_addr;
                    wdata_d  = pick_p1 ? p1_wdata : p0_wdata;
                    p0_gnt_d = ~pick_p1;
                    p1_gnt_d = pick_p1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (win_q) begin
                        p1_rdata_d = mem_data;
                    end else begin
                        p0_rdata_d = mem_data;
                    end
                end
                p0_done_d = ~win_q;
                p1_done_d = win_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_gnt_q   <= 1'b0;
            p1_gnt_q   <= 1'b0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p0_gnt_q   <= p0_gnt_d;
            p1_gnt_q   <= p1_gnt_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Strobes decode from the state flop so an asynchronous reset drops them at once.
    assign mem_read    = (state_q == ACCESS) & ~we_q;
    assign mem_write   = (state_q == ACCESS) & we_q;
    assign mem_address = addr_q;
    assign mem_acc     = wdata_q;

    assign p0_gnt   = p0_gnt_q;
    assign p1_gnt   = p1_gnt_q;
    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a transaction-level arbitration
// and memory model; honours DMEM_ARB_FIXED_PRIO_EN when defined.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [3:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_gnt, p0_done, p1_gnt, p1_done;
    logic [7:0] p0_rdata, p1_rdata;
    logic [3:0] mem_address;
    logic [7:0] mem_acc, mem_data;
    logic       mem_read, mem_write;

    int checks   = 0;
    int failures = 0;

    // Environment memory seen by the DUT, and the bench's own expectation of its contents.
    logic [7:0] tb_mem  [16];
    logic [7:0] ref_mem [16];

    // Pending-request bookkeeping per port and model state.
    logic       req_on    [2];
    logic       req_we    [2];
    logic [3:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic [7:0] exp_rdata [2];
    int         last_port;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_acc(mem_acc),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = tb_mem[mem_address];

    function automatic logic [33:0] all_outs();
        return {p0_gnt, p1_gnt, p0_done, p1_done, mem_read, mem_write,
                mem_address, mem_acc, p0_rdata, p1_rdata};
    endfunction

    function automatic int model_winner();
        if (req_on[0] && req_on[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (last_port == 1) ? 0 : 1;
`endif
        end
        return req_on[0] ? 0 : 1;
    endfunction

    task automatic apply();
        p0_req = req_on[0]; p0_we = req_we[0]; p0_addr = req_addr[0]; p0_wdata = req_wdata[0];
        p1_req = req_on[1]; p1_we = req_we[1]; p1_addr = req_addr[1]; p1_wdata = req_wdata[1];
    endtask

    task automatic set_req(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
        req_on[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = d;
    endtask

    task automatic model_reset();
        last_port = 1;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        for (int p = 0; p < 2; p++) req_on[p] = 1'b0;
    endtask

    // Advance one clock: commit any memory write at the edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (mem_write === 1'b1) tb_mem[mem_address] = mem_acc;
        #1;
        checks++;
        if ((mem_read & mem_write) | (p0_gnt & p1_gnt) | (p0_done & p1_done)) begin
            failures++;
            $display("FAIL exclusive: rd=%b wr=%b gnt=%b%b done=%b%b, required at most one of each pair",
                     mem_read, mem_write, p0_gnt, p1_gnt, p0_done, p1_done);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        apply();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One arbitration round starting in an IDLE cycle; the winner's fields are changed after the grant.
    task automatic round(input string name, input logic [3:0] post_addr, input logic [7:0] post_wdata,
                         output int obs_w);
        int         w;
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        w  = model_winner();
        wr = req_we[w]; a = req_addr[w]; d = req_wdata[w];
        apply();
        tick();
        obs_w = (p1_gnt === 1'b1) ? 1 : ((p0_gnt === 1'b1) ? 0 : -1);
        req_on[w] = 1'b0; req_we[w] = ~wr; req_addr[w] = post_addr; req_wdata[w] = post_wdata;
        apply();
        #1;
        checks++;
        if ({p0_gnt, p1_gnt} !== ((w == 0) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL %s gnt: got p0/p1=%b%b, required port %0d", name, p0_gnt, p1_gnt, w);
        end
        checks++;
        if (wr) begin
            if ({mem_read, mem_write, mem_address, mem_acc} !== {2'b01, a, d}) begin
                failures++;
                $display("FAIL %s write access: got rd=%b wr=%b addr=%h acc=%h, required rd=0 wr=1 addr=%h acc=%h",
                         name, mem_read, mem_write, mem_address, mem_acc, a, d);
            end
            ref_mem[a] = d;
        end else begin
            if ({mem_read, mem_write, mem_address} !== {2'b10, a}) begin
                failures++;
                $display("FAIL %s read access: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=%h",
                         name, mem_read, mem_write, mem_address, a);
            end
            exp_rdata[w] = ref_mem[a];
        end
        last_port = w;
        tick();
        checks++;
        if ({p0_done, p1_done, p0_gnt, p1_gnt, mem_read, mem_write} !== {((w == 0) ? 2'b10 : 2'b01), 4'b0000}) begin
            failures++;
            $display("FAIL %s done: got done=%b%b gnt=%b%b rd=%b wr=%b, required done for port %0d only",
                     name, p0_done, p1_done, p0_gnt, p1_gnt, mem_read, mem_write, w);
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
            failures++;
            $display("FAIL %s rdata: got p0=%h p1=%h, required p0=%h p1=%h",
                     name, p0_rdata, p1_rdata, exp_rdata[0], exp_rdata[1]);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        apply();
        #12;
        checks++;
        if (all_outs() !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (all_outs() !== 34'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got %h, required 0", all_outs());
        end
    endtask

    task automatic test_write_then_read();
        int obs;
        set_req(0, 1'b1, 4'd3, 8'hA5);
        round("p0_write_a3", 4'd9, 8'h00, obs);
        set_req(1, 1'b0, 4'd3, 8'h11);
        round("p1_read_a3", 4'd0, 8'h00, obs);
        checks++;
        if (p1_rdata !== 8'hA5) begin
            failures++;
            $display("FAIL p1_readback: got %h, required a5", p1_rdata);
        end
    endtask

    task automatic test_latched_fields();
        int obs;
        set_req(1, 1'b1, 4'd3, 8'h5A);
        round("p1_write_latched", 4'd7, 8'hFF, obs);
        set_req(0, 1'b0, 4'd7, 8'h00);
        round("p0_read_a7", 4'd0, 8'h00, obs);
        checks++;
        if (p0_rdata !== 8'h4B) begin
            failures++;
            $display("FAIL addr7_untouched: got %h, required 4b", p0_rdata);
        end
        set_req(0, 1'b0, 4'd3, 8'h00);
        round("p0_read_a3", 4'd0, 8'h00, obs);
        checks++;
        if (p0_rdata !== 8'h5A) begin
            failures++;
            $display("FAIL addr3_latched_write: got %h, required 5a", p0_rdata);
        end
    endtask

    task automatic test_contention();
        int obs;
        int seq     [4];
        int exp_seq [4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_on[p]) set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                                        8'($urandom_range(0, 255)));
            end
            round("contend", 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), obs);
            seq[r] = obs;
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (seq[r] !== exp_seq[r]) begin
                failures++;
                $display("FAIL contend_order[%0d]: got port %0d, required port %0d", r, seq[r], exp_seq[r]);
            end
        end
        model_reset();
        apply();
    endtask

    task automatic test_reset_mid_access();
        int obs;
        set_req(0, 1'b1, 4'd5, 8'hC3);
        apply();
        tick();
        checks++;
        if ({p0_gnt, mem_write} !== 2'b11) begin
            failures++;
            $display("FAIL midreset_setup: got gnt=%b wr=%b, required 1 1", p0_gnt, mem_write);
        end
        req_on[0] = 1'b0;
        apply();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, p0_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_async: got rd=%b wr=%b gnt=%b, required 0 0 0", mem_read, mem_write, p0_gnt);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({p0_done, p1_done} !== 2'b00) begin
                failures++;
                $display("FAIL midreset_no_done: got done=%b%b, required 00", p0_done, p1_done);
            end
        end
        reset = 1'b1;
        model_reset();
        tick();
        checks++;
        if (all_outs() !== 34'd0) begin
            failures++;
            $display("FAIL midreset_idle_bus: got %h, required 0", all_outs());
        end
        set_req(0, 1'b0, 4'd5, 8'h00);
        round("read_a5_after_reset", 4'd0, 8'h00, obs);
        checks++;
        if (p0_rdata !== 8'h69) begin
            failures++;
            $display("FAIL aborted_write_discarded: got %h, required 69", p0_rdata);
        end
    endtask

    task automatic test_continuous_p1();
        logic [3:0] a;
        a = 4'($urandom_range(0, 15));
        set_req(1, 1'b0, a, 8'h00);
        apply();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({p0_gnt, p1_gnt, p1_done, mem_read, mem_write} !==
                {1'b0, (i % 3 == 0), (i % 3 == 1), (i % 3 == 0), 1'b0}) begin
                failures++;
                $display("FAIL held_p1 cycle %0d: got gnt=%b%b done1=%b rd=%b wr=%b", i,
                         p0_gnt, p1_gnt, p1_done, mem_read, mem_write);
            end
            if (i % 3 == 1) begin
                checks++;
                if (p1_rdata !== ref_mem[a]) begin
                    failures++;
                    $display("FAIL held_p1_rdata: got %h, required %h", p1_rdata, ref_mem[a]);
                end
            end
        end
        req_on[1] = 1'b0;
        apply();
        exp_rdata[1] = ref_mem[a];
        last_port = 1;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            failures++;
            $display("FAIL held_p1_release: got gnt=%b%b, required 00", p0_gnt, p1_gnt);
        end
    endtask

    task automatic test_random();
        int obs;
        for (int r = 0; r < 30; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_on[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
            if (!req_on[0] && !req_on[1])
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                        8'($urandom_range(0, 255)));
            round("random", 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), obs);
        end
        req_on[0] = 1'b0;
        req_on[1] = 1'b0;
        apply();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 8'(i * 17) ^ 8'h3C;
            ref_mem[i] = 8'(i * 17) ^ 8'h3C;
        end
        for (int p = 0; p < 2; p++) begin
            req_we[p] = 1'b0; req_addr[p] = 4'd0; req_wdata[p] = 8'd0;
        end
        test_reset();
        test_write_then_read();
        test_latched_fields();
        test_contention();
        test_reset_mid_access();
        test_continuous_p1();
        test_random();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
